mem_slave: RTL and testbench

MEM_SLAVE -- requirements
Module: mem_slave

---
 rtl/mem_slave_pkg.sv | 20 ++
 rtl/mem_slave_ram.sv | 27 ++
 rtl/mem_slave.sv | 123 ++++++++++++
 tb/tb_mem_slave.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_slave_pkg.sv
// mem_slave_pkg: shared constants for the memory slave.
//   state_t     FSM encoding for mem_slave
//   WAIT_MAX    largest wait-state count the 4-bit counter can express
//   LINE_WORDS  cache line size in 32-bit words
//   LINE_BYTES  cache line size in bytes
package mem_slave_pkg;

   localparam int LINE_WORDS = 4;
   localparam int LINE_BYTES = LINE_WORDS * 4;

   localparam int WAIT_MAX = 15;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_ACK     = 2'd2,
      S_RECOVER = 2'd3
   } state_t;

endpackage

// File: rtl/mem_slave_ram.sv
// mem_slave_ram: single-port synchronous RAM, 2**ADDR_WIDTH x 32.
//   clk    clock
//   we     write enable: mem[addr] <= wdata
//   re     read enable:  rdata <= mem[addr] (rdata holds otherwise)
//   addr   word address
//   wdata  write data
//   rdata  registered read data
// Contents are never reset.
module mem_slave_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_slave.sv
// mem_slave: word-wide memory slave for the cache management unit, with a
// fixed number of wait states per access.
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   mem_cs_i    request valid
//   mem_we_i    1 = write, 0 = read
//   mem_addr_i  byte address, bits [ADDR_WIDTH+1:2] select the word
//   mem_data_i  write data
//   mem_data_o  read data, held until the next read ack
//   mem_ack_o   one-cycle completion pulse per word
module mem_slave
   import mem_slave_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_cs_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        mem_ack_o
);

   localparam int          W_EFF    = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
   localparam logic [3:0]  CNT_LAST = (W_EFF > 0) ? 4'(W_EFF - 1) : 4'd0;

   state_t                 state, state_nx;
   logic [3:0]             cnt;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic                   we_q;
   logic [31:0]            data_q;
   logic                   rd_vld;

   logic                   accept, go_ack, use_in;
   logic [ADDR_WIDTH-1:0]  ram_addr;
   logic                   ram_we, ram_re, we_sel;
   logic [31:0]            ram_wdata, ram_rdata;

   logic                   unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

   // S_RECOVER is the dead cycle after every ack; its closing edge samples
   // the next request exactly like S_IDLE, which gives the back-to-back
   // rate of one ack per WAIT_CYCLES+2 cycles.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      go_ack   = 1'b0;
      case (state)
         S_IDLE, S_RECOVER: begin
            state_nx = S_IDLE;
            if (mem_cs_i) begin
               accept = 1'b1;
               if (W_EFF == 0) begin
                  go_ack   = 1'b1;
                  state_nx = S_ACK;
               end else begin
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!mem_cs_i) begin
               state_nx = S_IDLE;
            end else if (cnt == CNT_LAST) begin
               go_ack   = 1'b1;
               state_nx = S_ACK;
            end
         end
         S_ACK:   state_nx = S_RECOVER;
         default: state_nx = S_IDLE;
      endcase
   end

   // With zero wait states the ack edge is the sampling edge, so the RAM
   // must see the live inputs; otherwise it always sees the latched copy.
   assign use_in    = (state == S_IDLE) || (state == S_RECOVER);
   assign ram_addr  = use_in ? mem_addr_i[ADDR_WIDTH+1:2] : addr_q;
   assign we_sel    = use_in ? mem_we_i : we_q;
   assign ram_wdata = use_in ? mem_data_i : data_q;
   assign ram_we    = go_ack && we_sel && !rst;
   assign ram_re    = go_ack && !we_sel && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         mem_ack_o <= 1'b0;
         rd_vld    <= 1'b0;
      end else begin
         state     <= state_nx;
         mem_ack_o <= go_ack;
         if (accept)                cnt <= 4'd0;
         else if (state == S_WAIT)  cnt <= cnt + 4'd1;
         if (ram_re)                rd_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= mem_addr_i[ADDR_WIDTH+1:2];
         we_q   <= mem_we_i;
         data_q <= mem_data_i;
      end
   end

   mem_slave_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // The RAM read register is only loaded on read acks, so it already holds
   // between acks; rd_vld forces the visible value to zero out of reset.
   assign mem_data_o = rd_vld ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_mem_slave.sv
module tb_mem_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // DUT with WAIT_CYCLES=4
   logic        cs = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic        ack;
   // DUT with WAIT_CYCLES=0
   logic        cs0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
   logic        ack0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   mem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .mem_cs_i(cs), .mem_we_i(we), .mem_addr_i(addr),
      .mem_data_i(wdata), .mem_data_o(rdata), .mem_ack_o(ack));

   mem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .mem_cs_i(cs0), .mem_we_i(we0), .mem_addr_i(addr0),
      .mem_data_i(wdata0), .mem_data_o(rdata0), .mem_ack_o(ack0));

   task automatic tick;
      @(posedge clk); #1; cyc++;
   endtask

   // Issue one request on the WAIT_CYCLES=4 DUT; edges=-1 on timeout.
   // ack_nx is the ack seen in the cycle after the ack cycle. Returns in S_IDLE.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int edges, output logic [31:0] rd, output logic ack_nx);
      cs = 1'b1; we = w; addr = a; wdata = d; edges = -1;
      for (int i = 1; i <= 20; i++) begin
         tick;
         if (ack === 1'b1) begin edges = i; break; end
      end
      rd = rdata;
      cs = 1'b0;
      tick;
      ack_nx = ack;
      tick;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      n_tests++; if (ack !== 1'b0)     begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
      n_tests++; if (rdata !== 32'd0)  begin n_fail++; $display("FAIL reset_data: got %h want 0", rdata); end
      n_tests++; if (ack0 !== 1'b0)    begin n_fail++; $display("FAIL reset_ack0: got %b want 0", ack0); end
      n_tests++; if (rdata0 !== 32'd0) begin n_fail++; $display("FAIL reset_data0: got %h want 0", rdata0); end
      rst = 1'b0;
   endtask

   task automatic test_write;
      int e; logic [31:0] rd; logic an;
      xfer(1'b1, 32'h10, 32'hDEADBEEF, e, rd, an);
      n_tests++; if (e != 5)        begin n_fail++; $display("FAIL write_latency: got %0d edges want 5", e); end
      n_tests++; if (an !== 1'b0)   begin n_fail++; $display("FAIL write_ack_width: ack after pulse %b want 0", an); end
      n_tests++; if (rd !== 32'd0)  begin n_fail++; $display("FAIL write_data_hold: got %h want 0", rd); end
   endtask

   task automatic test_read;
      int e; logic [31:0] rd; logic an;
      xfer(1'b0, 32'h10, 32'h0, e, rd, an);
      n_tests++; if (e != 5)              begin n_fail++; $display("FAIL read_latency: got %0d edges want 5", e); end
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", rd); end
      n_tests++; if (an !== 1'b0)         begin n_fail++; $display("FAIL read_ack_width: got %b want 0", an); end
      tick; tick;
      n_tests++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_hold: got %h want deadbeef", rdata); end
      xfer(1'b0, 32'h13, 32'h0, e, rd, an);
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_byte_offset: got %h want deadbeef", rd); end
      xfer(1'b0, 32'h1010, 32'h0, e, rd, an);
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_alias: got %h want deadbeef", rd); end
   endtask

   task automatic test_back_to_back;
      int e; logic [31:0] rd; logic an;
      int last; logic got;
      for (int k = 0; k < 4; k++)
         xfer(1'b1, 32'h40 + 32'(4*k), 32'hC0DE_0000 | 32'(k), e, rd, an);
      cs = 1'b1; we = 1'b0; addr = 32'h40; last = -1;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick;
            if (ack === 1'b1) begin got = 1'b1; break; end
         end
         n_tests++;
         if (!got) begin
            n_fail++; $display("FAIL b2b_timeout: word %0d no ack within 20 cycles", k);
         end else begin
            if (rdata !== (32'hC0DE_0000 | 32'(k))) begin
               n_fail++; $display("FAIL b2b_data: word %0d got %h want %h", k, rdata, 32'hC0DE_0000 | 32'(k));
            end
            if (k > 0) begin
               n_tests++;
               if (cyc - last != 6) begin n_fail++; $display("FAIL b2b_spacing: word %0d got %0d cycles want 6", k, cyc - last); end
            end
            last = cyc;
         end
         tick;
         if (k == 3) cs = 1'b0;
         else        addr = 32'h40 + 32'(4*(k+1));
      end
      tick;
   endtask

   task automatic test_abort;
      int e; logic [31:0] rd; logic an; int acks;
      xfer(1'b1, 32'h20, 32'hA5A5_0020, e, rd, an);
      xfer(1'b0, 32'h10, 32'h0, e, rd, an);   // leaves rdata = deadbeef
      cs = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; acks = 0;
      tick; if (ack === 1'b1) acks++;
      tick; if (ack === 1'b1) acks++;
      tick; if (ack === 1'b1) acks++;
      cs = 1'b0; addr = 32'h0; wdata = 32'h0;
      for (int i = 0; i < 8; i++) begin tick; if (ack === 1'b1) acks++; end
      n_tests++; if (acks != 0)             begin n_fail++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
      n_tests++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL abort_data_hold: got %h want deadbeef", rdata); end
      xfer(1'b0, 32'h20, 32'h0, e, rd, an);
      n_tests++; if (rd !== 32'hA5A5_0020)  begin n_fail++; $display("FAIL abort_no_write: got %h want a5a50020", rd); end
   endtask

   task automatic test_reset_at_ack;
      int e; logic [31:0] rd; logic an;
      xfer(1'b1, 32'h30, 32'h0BAD_F00D, e, rd, an);
      xfer(1'b0, 32'h30, 32'h0, e, rd, an);
      n_tests++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_ack_prior: got %h want 0badf00d", rd); end
      cs = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hFFFF_0000;
      tick; tick; tick; tick;   // sampling edge + 3 wait edges
      rst = 1'b1;
      tick;                     // would have entered S_ACK
      n_tests++; if (ack !== 1'b0)    begin n_fail++; $display("FAIL rst_ack_ack: got %b want 0", ack); end
      n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_ack_data: got %h want 0", rdata); end
      rst = 1'b0; cs = 1'b0;
      tick;
      n_tests++; if (ack !== 1'b0)    begin n_fail++; $display("FAIL rst_ack_after: got %b want 0", ack); end
      xfer(1'b0, 32'h30, 32'h0, e, rd, an);
      n_tests++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_ack_no_write: got %h want 0badf00d", rd); end
   endtask

   task automatic test_wait0;
      cs0 = 1'b1; we0 = 1'b1; addr0 = 32'h1000; wdata0 = 32'h1;
      tick;
      n_tests++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL w0_write_ack: got %b want 1", ack0); end
      cs0 = 1'b0;
      tick;
      n_tests++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL w0_ack_width: got %b want 0", ack0); end
      tick;
      cs0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
      tick;
      n_tests++; if (ack0 !== 1'b1)      begin n_fail++; $display("FAIL w0_read_ack: got %b want 1", ack0); end
      n_tests++; if (rdata0 !== 32'h1)   begin n_fail++; $display("FAIL w0_alias_data: got %h want 1", rdata0); end
      tick;   // S_RECOVER
      n_tests++; if (ack0 !== 1'b0)      begin n_fail++; $display("FAIL w0_recover: got %b want 0", ack0); end
      tick;   // sampled again at recover exit
      n_tests++; if (ack0 !== 1'b1)      begin n_fail++; $display("FAIL w0_b2b_ack: got %b want 1", ack0); end
      cs0 = 1'b0;
      tick; tick;
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_back_to_back;
      test_abort;
      test_reset_at_ack;
      test_wait0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
